// File: rtl/display_pkg.sv
// Shared constants for the four-digit seven-segment scan controller:
// digit count, data width and the active-low {g,f,e,d,c,b,a} patterns.
package display_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int IDX_W      = $clog2(NUM_DIGITS);
   localparam int DATA_W     = 4 * NUM_DIGITS;

   typedef logic [IDX_W-1:0] digit_idx_t;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-decimal nibbles (10..15) decode to a dark digit.
module seg7_decode
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Map one BCD nibble to its segment pattern
   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
      seg = SEG_BLANK;
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// A prescaler divides clk into digit slots; each slot starts with one dead
// cycle (all anodes off) while the registered segment pattern settles.
// New digits are accepted only at frame boundaries into a shadow register,
// so a frame never mixes old and new values.
// Optional feature: define DISPLAY_BLINK_EN to enable per-digit blinking.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLINK_FRAMES = 64
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] digits_in,
   input  logic              upd_valid,
   output logic              upd_ready,
   input  logic [3:0]        blank_mask,
   input  logic [3:0]        blink_mask,
   output logic [6:0]        seg,
   output logic [3:0]        an
);

   localparam int               CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam digit_idx_t       IDX_LAST = digit_idx_t'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   digit_idx_t        idx_q, idx_d;
   logic [DATA_W-1:0] shadow_q, shadow_d;
   logic [6:0]        seg_q, seg_d;
   logic [3:0]        an_q, an_d;
   logic              tick;
   logic              frame_end;
   logic              blink_dark;
   logic              dark;
   logic [3:0]        nib;
   logic [6:0]        dec_seg;

   assign tick      = (cnt_q == CNT_LAST);
   assign frame_end = tick && (idx_q == IDX_LAST);
   assign upd_ready = frame_end;

`ifdef DISPLAY_BLINK_EN
   localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

   logic [FRM_W-1:0] frm_q, frm_d;
   logic             phase_q, phase_d;

   // Count frame boundaries and flip the blink phase every BLINK_FRAMES of them
   always_comb begin
      frm_d   = frm_q;
      phase_d = phase_q;
      if (frame_end) begin
         if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
            frm_d   = '0;
            phase_d = ~phase_q;
         end else begin
            frm_d = frm_q + FRM_W'(1);
         end
      end
   end

   // Blink counter and phase registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frm_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         frm_q   <= frm_d;
         phase_q <= phase_d;
      end
   end

   // The digit entering its slot uses the phase that applies from this edge on
   assign blink_dark = phase_d & blink_mask[idx_d];
`else
   logic unused_blink;
   assign unused_blink = (^blink_mask) ^ (BLINK_FRAMES < 1);
   assign blink_dark   = 1'b0;
`endif

   seg7_decode u_decode (
      .nibble (nib),
      .seg    (dec_seg)
   );

   // Next-state for prescaler, digit index, shadow, anodes and segments
   always_comb begin
      cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d    = idx_q;
      shadow_d = shadow_q;
      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + digit_idx_t'(1);
      end
      if (frame_end && upd_valid) begin
         shadow_d = digits_in;
      end
      // Look up the digit that owns the slot starting on this edge, using the
      // shadow value as it stands after a possible load on the same edge
      nib   = shadow_d[{idx_d, 2'b00} +: 4];
      dark  = blank_mask[idx_d] | blink_dark;
      an_d  = tick ? 4'b1111 : ~(4'b0001 << idx_q);
      seg_d = seg_q;
      if (tick) begin
         seg_d = dark ? SEG_BLANK : dec_seg;
      end
   end

   // State registers; reset blanks the display immediately
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is written with non-blocking assignments so all flops update together.
      if (!rst_n) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         seg_q    <= SEG_BLANK;
         an_q     <= 4'b1111;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (REFRESH_DIV=4, BLINK_FRAMES=2).
// Each digit slot gets an expectation pushed by a small behavioural model,
// then popped and compared when the DUT opens that slot.
`timescale 1ns/1ps
module tb_display_scan_ctrl;

   localparam int DIV = 4;
   localparam int BF  = 2;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic [15:0] digits_in  = 16'h0000;
   logic        upd_valid  = 1'b0;
   logic        upd_ready;
   logic [3:0]  blank_mask = 4'b0000;
   logic [3:0]  blink_mask = 4'b0000;
   logic [6:0]  seg;
   logic [3:0]  an;

   display_scan_ctrl #(
      .REFRESH_DIV  (DIV),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digits_in  (digits_in),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .blank_mask (blank_mask),
      .blink_mask (blink_mask),
      .seg        (seg),
      .an         (an)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] seg;
      logic [3:0] an;
      int         ready;
   } exp_t;

   exp_t       sb[$];
   logic [6:0] seg_tbl [16];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         last_rdy = -1;
   int         m_idx;
   int         m_bcount;
   logic [15:0] m_shadow;
   logic [6:0]  last_exp_seg;
   logic [15:0] garb [3];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic neg_sample();
      @(negedge clk);
      cyc++;
   endtask

   task automatic model_reset();
      m_idx        = 0;
      m_bcount     = 0;
      m_shadow     = 16'h0000;
      last_exp_seg = 7'b1111111;
      last_rdy     = -1;
      sb.delete();
   endtask

   // Predict the next slot from the inputs that will be present at its tick
   task automatic model_advance();
      exp_t       e;
      bit         boundary;
      bit         dk;
      logic [3:0] nib;
      boundary = (m_idx == 3);
      m_idx    = (m_idx + 1) % 4;
      if (boundary) begin
         if (upd_valid) m_shadow = digits_in;
         m_bcount++;
      end
      nib = m_shadow[m_idx*4 +: 4];
      dk  = blank_mask[m_idx];
`ifdef DISPLAY_BLINK_EN
      if ((((m_bcount / BF) % 2) == 1) && blink_mask[m_idx]) dk = 1'b1;
`endif
      e.seg       = dk ? 7'b1111111 : seg_tbl[nib];
      e.an        = 4'b1111;
      e.an[m_idx] = 1'b0;
      e.ready     = boundary ? 1 : 0;
      sb.push_back(e);
   endtask

   // Wait for the next slot to open and compare it against the scoreboard
   task automatic wait_slot(input string tag);
      int         dead;
      int         samples;
      int         rdy;
      bit         found;
      logic [6:0] dead_seg;
      logic [6:0] prev_lit;
      exp_t       e;
      dead = 0; samples = 0; rdy = 0; found = 1'b0;
      dead_seg = 7'h00; prev_lit = 7'h00;
      for (int i = 0; i < 3*DIV && !found; i++) begin
         neg_sample();
         samples++;
         if (upd_ready === 1'b1) begin
            rdy++;
            if (last_rdy >= 0) check({tag, " ready spacing"}, 16'(cyc - last_rdy), 16'(4*DIV));
            last_rdy = cyc;
         end
         if (an === 4'b1111) begin
            dead++;
            dead_seg = seg;
         end else if (dead > 0) begin
            found = 1'b1;
         end else begin
            prev_lit = seg;
         end
      end
      e = sb.pop_front();
      check({tag, " slot opened"}, 16'(found), 16'd1);
      if (found) begin
         check({tag, " dead cycles"}, 16'(dead), 16'd1);
         check({tag, " slot length"}, 16'(samples), 16'(DIV));
         check({tag, " seg in dead cycle"}, 16'(dead_seg), 16'(e.seg));
         check({tag, " seg"}, 16'(seg), 16'(e.seg));
         check({tag, " an"}, 16'(an), 16'(e.an));
         check({tag, " ready pulses"}, 16'(rdy), 16'(e.ready));
         if (e.seg !== last_exp_seg)
            check({tag, " seg changed at tick"}, 16'(dead_seg !== prev_lit), 16'd1);
      end
      last_exp_seg = e.seg;
   endtask

   task automatic slot(input string tag);
      model_advance();
      wait_slot(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " an"}, 16'(an), 16'h000F);
      check({tag, " seg"}, 16'(seg), 16'h007F);
      check({tag, " upd_ready"}, 16'(upd_ready), 16'h0000);
   endtask

   // First slot after release: digit 0 anode, segments still blank from reset
   task automatic release_reset(input string tag);
      rst_n = 1'b1;
      neg_sample();
      check({tag, " first slot an"}, 16'(an), 16'h000E);
      check({tag, " first slot seg"}, 16'(seg), 16'h007F);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001;
      seg_tbl[2] = 7'b0100100; seg_tbl[3] = 7'b0110000;
      seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
      seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000;
      seg_tbl[8] = 7'b0000000; seg_tbl[9] = 7'b0010000;
      for (int i = 10; i < 16; i++) seg_tbl[i] = 7'b1111111;
      garb[0] = 16'h9012; garb[1] = 16'h3344; garb[2] = 16'hFFFF;
      model_reset();

      // Reset state, then load 1234 at the first boundary
      neg_sample();
      neg_sample();
      check_reset_outputs("reset");
      upd_valid = 1'b1;
      digits_in = 16'h1234;
      release_reset("A");
      slot("A d1");
      slot("A d2");
      slot("A d3");
      slot("A d0 load 1234");
      upd_valid = 1'b0;
      slot("A d1 shows 3");
      slot("A d2");
      slot("A d3");
      slot("A d0 hold");

      // upd_valid held high; mid-frame digits_in changes must not show
      upd_valid = 1'b1;
      digits_in = 16'h5678;
      slot("B d1");
      slot("B d2");
      slot("B d3");
      slot("B d0");
      for (int f = 0; f < 3; f++) begin
         digits_in = garb[f];
         slot("B held d1");
         slot("B held d2");
         slot("B held d3");
         digits_in = 16'h5678;
         slot("B held d0");
      end

      // Non-decimal nibbles decode dark, then blank_mask darkens digit 2
      digits_in = 16'h00AF;
      slot("C d1");
      slot("C d2");
      slot("C d3");
      slot("C d0 F dark");
      upd_valid = 1'b0;
      slot("C d1 A dark");
      slot("C d2");
      slot("C d3");
      slot("C d0");
      blank_mask = 4'b0100;
      slot("C d1 masked run");
      slot("C d2 blanked");
      slot("C d3 masked run");
      slot("C d0 masked run");
      blank_mask = 4'b0000;

      // Mid-slot asynchronous reset after loading 9999
      upd_valid = 1'b1;
      digits_in = 16'h9999;
      slot("E d1");
      slot("E d2");
      slot("E d3");
      slot("E d0 load 9999");
      upd_valid = 1'b0;
      slot("E d1 shows 9");
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async reset");
      model_reset();
      neg_sample();
      neg_sample();
      check_reset_outputs("held reset");

      // Blink run from a fresh reset so frames count from zero
      blink_mask = 4'b0001;
      release_reset("E");
      slot("E d1 after reset");
      for (int s = 0; s < 19; s++) slot($sformatf("D blink frame %0d digit %0d", m_bcount, (m_idx + 1) % 4));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
